// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path.
//
// Contents:
//   XLEN          - datapath width (PC, addresses, instruction words)
//   RESET_PC      - PC loaded on reset
//   NOP_INSTR     - bubble instruction (addi x0,x0,0) presented when nothing is valid
//   fetch_state_e - fetch FSM states: StFetch, StWait, StHold
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // StFetch: request issued to imem; StWait: one request outstanding;
    // StHold: response parked in the skid buffer while decode is stalled.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StWait  = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register between fetch and decode.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   flush_i    in   force a bubble (highest priority, overrides stall)
//   load_i     in   capture instr_i / pc_i as a valid instruction
//   stall_i    in   hold current contents when nothing is loaded or flushed
//   instr_i    in   instruction word to capture
//   pc_i       in   PC of instr_i
//   instr_o    out  registered instruction (NOP_INSTR when not valid)
//   pc_o       out  registered PC
//   pc_plus4_o out  registered PC+4
//   valid_o    out  registered instruction is real
module if_id_reg #(
    parameter int unsigned         XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_i + XLEN'(4);
            valid_d    = 1'b1;
        end else if (!stall_i) begin
            // Decode consumed the previous entry and nothing new arrived.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time over a
// grant/valid handshake and hands fetched words to decode through the IF/ID register.
// Branch redirects from execute take priority over everything, including stall.
//
// Ports:
//   clk             in   clock
//   rst             in   asynchronous active-low reset
//   imem_req        out  fetch request valid (state-only, never depends on imem_gnt)
//   imem_addr       out  fetch address (current PC)
//   imem_gnt        in   memory accepts the request this cycle
//   imem_rvalid     in   response data valid
//   imem_rdata      in   instruction word
//   redirect        in   branch taken
//   redirect_target in   branch target (low two bits ignored)
//   stall           in   decode cannot accept; hold IF/ID contents
//   InstrD          out  instruction to decoder
//   PCD             out  PC of InstrD
//   PCPlus4D        out  PCD + 4
//   ValidD          out  InstrD holds a real instruction
module fetch_stage #(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    import riscv_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] skid_q, skid_d;
    logic            drop_q, drop_d;

    logic            can_load;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = redirect_target & ~XLEN'(3);

    // IF/ID can take a new word if it is empty or decode is consuming it.
    assign can_load = !ValidD || !stall;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        skid_d     = skid_q;
        drop_d     = drop_q;
        ifid_load  = 1'b0;
        ifid_instr = imem_rdata;

        unique case (state_q)
            StFetch: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = StWait;
                    // The granted request is for the old path; its data must be thrown away.
                    if (redirect) drop_d = 1'b1;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = StFetch;
                    drop_d  = 1'b0;
                    if (!redirect && !drop_q) begin
                        if (can_load) begin
                            ifid_load = 1'b1;
                        end else begin
                            skid_d  = imem_rdata;
                            state_d = StHold;
                        end
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                ifid_instr = skid_q;
                if (redirect) begin
                    state_d = StFetch;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (redirect) begin
            pc_d   = redirect_pc;
            skid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            skid_q   <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            skid_q   <= skid_d;
            drop_q   <= drop_d;
        end
    end

    // Reset gates the request so nothing is issued while rst is held low.
    assign imem_req  = rst && (state_q == StFetch);
    assign imem_addr = pc_q;

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect),
        .load_i     (ifid_load),
        .stall_i    (stall),
        .instr_i    (ifid_instr),
        .pc_i       (req_pc_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the main decoder. It owns the program counter and issues one request at a time to instruction memory over a grant/valid handshake. It presents the fetched instruction, with its PC and PC+4, through an IF/ID output register to decode. It consumes the branch-taken redirect (PCsrc with its target) coming back from execute, and honours a stall from the hazard logic.

Parameters:
XLEN, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on InstrD whenever ValidD=0

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (pc_f)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  XLEN  instruction word
redirect  in  1  branch taken (PCsrc from execute)
redirect_target  in  XLEN  branch target address
stall  in  1  decode cannot accept; hold IF/ID contents
InstrD  out  XLEN  instruction to decoder
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  InstrD holds a real instruction

Behaviour:
- Reset (rst=0, async): pc_f=RESET_PC, state=FETCH, drop=0, skid buffer empty, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0. imem_req=0 while rst=0.
- States: FETCH, WAIT, HOLD. At most one request is outstanding.
- imem_req=1 only in FETCH, and is a function of state only (no combinational path from imem_gnt). imem_addr=pc_f.
- FETCH: on imem_gnt: req_pc<=pc_f, pc_f<=pc_f+4 (mod 2^32, wraps 32'hFFFF_FFFC to 0), go to WAIT. Otherwise stay in FETCH.
- WAIT: on imem_rvalid:
  - if drop=1: discard the data, clear drop, go to FETCH.
  - else if the IF/ID register can load (ValidD=0 or stall=0): InstrD<=imem_rdata, PCD<=req_pc, PCPlus4D<=req_pc+4, ValidD<=1, go to FETCH.
  - else: capture the response in the skid buffer and go to HOLD.
- HOLD: no request issued. When stall=0, move the skid buffer into IF/ID and go to FETCH.
- IF/ID register: when stall=0 and no new instruction arrives, ValidD<=0 and InstrD<=NOP_INSTR (bubble). When stall=1, all IF/ID outputs are held unchanged.
- Latency: imem_gnt in cycle N, earliest imem_rvalid in N+1, ValidD=1 in N+2. Peak throughput is 1 instruction per 2 cycles.
- Redirect has highest priority and overrides stall in the same cycle:
  - pc_f<=redirect_target with bits[1:0] forced to 0.
  - ValidD<=0, InstrD<=NOP_INSTR, skid buffer cleared.
  - FETCH with imem_gnt in the same cycle: the stale request is accepted; go to WAIT with drop=1.
  - FETCH without grant: stay in FETCH; the next request uses the new pc_f.
  - WAIT without rvalid: drop<=1, stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the response, go to FETCH.
  - HOLD: go to FETCH.
  - drop, once set, stays set until the discarded response arrives.
- imem_rvalid outside WAIT is ignored (protocol error; assertion in bench).

Decomposition:
- Shared package riscv_pkg: XLEN, NOP_INSTR, RESET_PC, fetch state enum (FETCH/WAIT/HOLD).
- One sub-module, if_id_reg: holds InstrD/PCD/PCPlus4D/ValidD with load, hold (stall), flush-to-bubble controls, and async active-low reset.
- FSM, pc_f, req_pc, drop flag and skid buffer live in fetch_stage.

Test Plan:
- Reset release, memory with 1-cycle latency returning 0x00500093 at 0x0 → imem_addr 0x0 first, ValidD=1 two cycles after grant, PCD=0x0, PCPlus4D=0x4; next request issued at 0x4.
- stall=1 held while a response for 0x8 arrives → response goes to the skid buffer (HOLD), no imem_req, IF/ID unchanged; on stall=0 → InstrD=word@0x8, PCD=0x8 next cycle.
- redirect=1 target 0x100 while in WAIT for 0xC → response for 0xC discarded (ValidD stays 0), next imem_addr=0x100, PCD=0x100 delivered.
- redirect and stall both 1 with ValidD=1 → ValidD=0, InstrD=0x00000013 next cycle (redirect wins).
- redirect target 0x203 → fetch address 0x200.
- pc_f=0xFFFFFFFC fetched → next imem_addr=0x0, PCPlus4D=0x0; async reset asserted mid-WAIT → all outputs return to reset values immediately and fetch restarts at RESET_PC.
